// File: rtl/wb_sram_burst.sv
// Wishbone B4 registered-feedback SRAM slave with CTI/BTE bursts, byte lanes
// and an out-of-range error response.
module wb_sram_burst #(
    parameter int    MEM_ADDR_BITS    = 10,
    parameter int    WB_ADDRESS_WIDTH = 32,
    parameter int    WB_DATA_WIDTH    = 32,
    parameter int    RANGE_CHECK      = 1,
    parameter string INIT_FILE        = ""
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [WB_ADDRESS_WIDTH-1:0]   adr,
    input  logic [WB_DATA_WIDTH-1:0]      dat_w,
    output logic [WB_DATA_WIDTH-1:0]      dat_r,
    input  logic [WB_DATA_WIDTH/8-1:0]    sel,
    input  logic                          cyc,
    input  logic                          stb,
    input  logic                          we,
    input  logic [2:0]                    cti,
    input  logic [1:0]                    bte,
    output logic                          ack,
    output logic                          err
);
    localparam int SEL_W = WB_DATA_WIDTH / 8;
    localparam int ALIGN = $clog2(SEL_W);
    localparam int DEPTH = 2 ** MEM_ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        BURST  = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                      state_r;
    logic                        ack_r;
    logic                        err_r;
    logic [MEM_ADDR_BITS-1:0]    baddr_r;
    logic [WB_DATA_WIDTH-1:0]    mem [DEPTH];

    logic [MEM_ADDR_BITS-1:0]    widx_s;
    logic [MEM_ADDR_BITS-1:0]    next_s;
    logic                        oor_s;
    logic                        wr_en_s;
    logic                        unused_s;

    // Wrapping bursts only advance the low bits inside their 4/8/16-word block.
    function automatic logic [MEM_ADDR_BITS-1:0] next_addr(
        input logic [MEM_ADDR_BITS-1:0] a,
        input logic [1:0]               b
    );
        logic [MEM_ADDR_BITS-1:0] inc;
        inc = a + {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};
        case (b)
            2'b00:   return inc;
            2'b01:   return {a[MEM_ADDR_BITS-1:2], inc[1:0]};
            2'b10:   return {a[MEM_ADDR_BITS-1:3], inc[2:0]};
            2'b11:   return {a[MEM_ADDR_BITS-1:4], inc[3:0]};
            default: return inc;
        endcase
    endfunction

    assign widx_s   = adr[MEM_ADDR_BITS+ALIGN-1:ALIGN];
    assign oor_s    = (RANGE_CHECK != 0) &&
                      (adr[WB_ADDRESS_WIDTH-1:MEM_ADDR_BITS+ALIGN] != '0);
    assign next_s   = next_addr(baddr_r, bte);
    assign unused_s = ^adr;

    assign ack = ack_r & cyc & stb;
    assign err = err_r & cyc & stb;

    // ack_r is only ever set in SINGLE/BURST, so baddr_r always names the beat being written.
    assign wr_en_s = rstn & cyc & stb & ack_r & we;

    // Byte-lane memory write at the committing edge.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (sel[i]) begin
                    mem[baddr_r][8*i +: 8] <= dat_w[8*i +: 8];
                end
            end
        end
    end

    // Transfer FSM with registered ack/err flags and read-data register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            dat_r   <= '0;
            baddr_r <= '0;
        end else if (!cyc) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (stb) begin
                        if (oor_s) begin
                            state_r <= ERR;
                            err_r   <= 1'b1;
                        end else begin
                            state_r <= (cti == 3'b010) ? BURST : SINGLE;
                            ack_r   <= 1'b1;
                            baddr_r <= widx_s;
                            dat_r   <= mem[widx_s];
                        end
                    end
                end
                SINGLE: begin
                    if (stb) begin
                        state_r <= IDLE;
                        ack_r   <= 1'b0;
                    end
                end
                BURST: begin
                    // Prefetch the next beat so the following ack carries no wait state.
                    if (stb) begin
                        if (cti == 3'b010) begin
                            baddr_r <= next_s;
                            dat_r   <= mem[next_s];
                        end else begin
                            state_r <= IDLE;
                            ack_r   <= 1'b0;
                        end
                    end
                end
                ERR: begin
                    if (stb) begin
                        state_r <= IDLE;
                        err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ack_r   <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end
endmodule
